// File: rtl/fire_expand_pkg.sv
// Shared constants, fixed-point types and the saturating-add helper for the
// fire4/fire5 expand-3x3 convolution engine.
package fire_expand_pkg;

  localparam int WIDTH      = 16;
  localparam int ACC_W      = 2 * WIDTH;
  localparam int KERNEL_DIM = 3;
  localparam int CHIN       = 32;
  localparam int CHOUT      = 128;
  localparam int WOUT       = 32;
  localparam int DSP_NO     = CHOUT;
  localparam int WINDOW_LEN = KERNEL_DIM * KERNEL_DIM * CHIN;

  typedef logic signed [WIDTH-1:0] pix_t;
  typedef logic signed [WIDTH-1:0] ker_t;
  typedef logic signed [ACC_W-1:0] acc_t;

  // The layer top requantises by keeping the sign and a 15-bit magnitude window.
  localparam int RQ_SIGN_BIT = 31;
  localparam int RQ_MAG_MSB  = 28;
  localparam int RQ_MAG_LSB  = 14;

  localparam acc_t ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam acc_t ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  typedef struct packed {
    acc_t sum;
    logic ovf;
  } sat_add_t;

  // Signed add with overflow flag; clamps to the acc_t range when saturate is set.
  function automatic sat_add_t sat_add(input acc_t a, input acc_t b, input logic saturate);
    sat_add_t res;
    acc_t     sum;
    logic     pos_ovf;
    logic     neg_ovf;
    sum     = a + b;
    pos_ovf = ~a[ACC_W-1] & ~b[ACC_W-1] & sum[ACC_W-1];
    neg_ovf = a[ACC_W-1] & b[ACC_W-1] & ~sum[ACC_W-1];
    res.ovf = pos_ovf | neg_ovf;
    if (saturate && pos_ovf) begin
      res.sum = ACC_MAX;
    end else if (saturate && neg_ovf) begin
      res.sum = ACC_MIN;
    end else begin
      res.sum = sum;
    end
    return res;
  endfunction

endpackage

// File: rtl/conv_mac_lane_if.sv
// Operand/result bundle between the layer top (master) and one MAC lane (slave).
interface conv_mac_lane_if #(
  parameter int WIDTH = fire_expand_pkg::WIDTH,
  parameter int ACC_W = fire_expand_pkg::ACC_W
);

  // No valid/ready pair: layer_en qualifies pix/ker every cycle, clr restarts
  // the window, and the lane can never stall, so there is no backpressure.
  logic                    clr;
  logic                    layer_en;
  logic signed [WIDTH-1:0] pix;
  logic signed [WIDTH-1:0] ker;
  logic signed [ACC_W-1:0] mul_out;
  logic                    ovf;

  modport master (
    output clr, layer_en, pix, ker,
    input  mul_out, ovf
  );

  modport slave (
    input  clr, layer_en, pix, ker,
    output mul_out, ovf
  );

endinterface

// File: rtl/conv_mac_lane.sv
// One signed multiply-accumulate lane: combinational product, single
// accumulator register with clear, hold, wrap/saturate and sticky overflow.
module conv_mac_lane #(
  parameter int WIDTH    = fire_expand_pkg::WIDTH,
  parameter int ACC_W    = fire_expand_pkg::ACC_W,
  parameter bit SATURATE = 1'b0
) (
  input  logic           clk,
  input  logic           rst,
  conv_mac_lane_if.slave lane
);

  localparam int PW = 2 * WIDTH;

  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  generate
    if (ACC_W < PW) begin : g_bad_acc_w
      $error("conv_mac_lane: ACC_W must be at least 2*WIDTH");
    end
  endgenerate

  logic signed [PW-1:0]    w_pix_x;
  logic signed [PW-1:0]    w_ker_x;
  logic signed [PW-1:0]    w_prod;
  logic signed [ACC_W-1:0] w_prod_x;
  logic signed [ACC_W-1:0] w_sum;
  logic                    w_ovf_pos;
  logic                    w_ovf_neg;
  logic signed [ACC_W-1:0] w_acc_next;

  logic signed [ACC_W-1:0] r_acc;
  logic                    r_ovf;

  // Widen before multiplying so the full 2*WIDTH product is kept.
  assign w_pix_x  = PW'(lane.pix);
  assign w_ker_x  = PW'(lane.ker);
  assign w_prod   = w_pix_x * w_ker_x;
  assign w_prod_x = ACC_W'(w_prod);

  assign w_sum     = r_acc + w_prod_x;
  assign w_ovf_pos = ~r_acc[ACC_W-1] & ~w_prod_x[ACC_W-1] &  w_sum[ACC_W-1];
  assign w_ovf_neg =  r_acc[ACC_W-1] &  w_prod_x[ACC_W-1] & ~w_sum[ACC_W-1];

  always_comb begin
    w_acc_next = w_sum;
    if (SATURATE && w_ovf_pos) begin
      w_acc_next = ACC_MAX;
    end else if (SATURATE && w_ovf_neg) begin
      w_acc_next = ACC_MIN;
    end
  end

  // A clear with layer_en loads the current product so no sample is dropped
  // between consecutive windows.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc <= '0;
      r_ovf <= 1'b0;
    end else if (lane.clr) begin
      r_acc <= lane.layer_en ? w_prod_x : '0;
      r_ovf <= 1'b0;
    end else if (lane.layer_en) begin
      r_acc <= w_acc_next;
      if (w_ovf_pos || w_ovf_neg) begin
        r_ovf <= 1'b1;
      end
    end
  end

  assign lane.mul_out = r_acc;
  assign lane.ovf     = r_ovf;

endmodule

// File: tb/tb_conv_mac_lane.sv
// Directed scoreboard bench: a wrapping and a saturating lane share one stimulus
// stream, each cycle's hand-computed expectation is queued and checked by a monitor.
module tb_conv_mac_lane;

  localparam int W  = 16;
  localparam int AW = 32;
  localparam int EW = 2 * (AW + 1);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  conv_mac_lane_if #(.WIDTH(W), .ACC_W(AW)) lane_wrap ();
  conv_mac_lane_if #(.WIDTH(W), .ACC_W(AW)) lane_sat ();

  conv_mac_lane #(.WIDTH(W), .ACC_W(AW), .SATURATE(1'b0)) dut_wrap (
    .clk  (clk),
    .rst  (rst),
    .lane (lane_wrap)
  );

  conv_mac_lane #(.WIDTH(W), .ACC_W(AW), .SATURATE(1'b1)) dut_sat (
    .clk  (clk),
    .rst  (rst),
    .lane (lane_sat)
  );

  // Entry layout: {ovf_sat, acc_sat, ovf_wrap, acc_wrap}
  logic [EW-1:0] exp_q[$];
  string         name_q[$];
  int            checks = 0;
  int            errors = 0;

  task automatic drive(input logic r, input logic c, input logic en, input int p, input int k,
                       input logic [AW-1:0] e_wrap, input logic o_wrap,
                       input logic [AW-1:0] e_sat, input logic o_sat, input string nm);
    @(negedge clk);
    rst                = r;
    lane_wrap.clr      = c;
    lane_wrap.layer_en = en;
    lane_wrap.pix      = W'(p);
    lane_wrap.ker      = W'(k);
    lane_sat.clr       = c;
    lane_sat.layer_en  = en;
    lane_sat.pix       = W'(p);
    lane_sat.ker       = W'(k);
    exp_q.push_back({o_sat, e_sat, o_wrap, e_wrap});
    name_q.push_back(nm);
  endtask

  task automatic drive_same(input logic r, input logic c, input logic en, input int p, input int k,
                            input logic [AW-1:0] e, input logic o, input string nm);
    drive(r, c, en, p, k, e, o, e, o, nm);
  endtask

  // Monitor: each entry describes the state after the edge following its push.
  initial begin
    logic [EW-1:0] ent;
    string         nm;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        ent = exp_q.pop_front();
        nm  = name_q.pop_front();
        checks++;
        if (lane_wrap.mul_out !== ent[AW-1:0] || lane_wrap.ovf !== ent[AW]) begin
          errors++;
          $display("FAIL %s (wrap): mul_out=%h ovf=%b expected mul_out=%h ovf=%b",
                   nm, lane_wrap.mul_out, lane_wrap.ovf, ent[AW-1:0], ent[AW]);
        end
        checks++;
        if (lane_sat.mul_out !== ent[2*AW:AW+1] || lane_sat.ovf !== ent[EW-1]) begin
          errors++;
          $display("FAIL %s (sat): mul_out=%h ovf=%b expected mul_out=%h ovf=%b",
                   nm, lane_sat.mul_out, lane_sat.ovf, ent[2*AW:AW+1], ent[EW-1]);
        end
      end
    end
  end

  initial begin
    lane_wrap.clr      = 1'b0;
    lane_wrap.layer_en = 1'b0;
    lane_wrap.pix      = '0;
    lane_wrap.ker      = '0;
    lane_sat.clr       = 1'b0;
    lane_sat.layer_en  = 1'b0;
    lane_sat.pix       = '0;
    lane_sat.ker       = '0;

    // Reset holds the accumulator at zero despite layer_en and a live product.
    drive_same(1, 0, 1, 5, 7, 0, 0, "reset_0");
    drive_same(1, 0, 1, 5, 7, 0, 0, "reset_1");
    drive_same(0, 0, 1, 5, 7, 35, 0, "first_accumulate");

    drive_same(0, 1, 1, 3, -4, -12, 0, "basic_clr");
    drive_same(0, 0, 1, 2, 10, 8, 0, "basic_acc_1");
    drive_same(0, 0, 1, 2, 10, 28, 0, "basic_acc_2");

    // Full 288-sample window, then restart with the clr cycle's own product.
    drive_same(0, 1, 1, 1, 1, 1, 0, "window_start");
    for (int i = 2; i <= 288; i++) begin
      drive_same(0, 0, 1, 1, 1, i, 0, "window_acc");
    end
    drive_same(0, 1, 1, 2, 3, 6, 0, "window_restart");

    for (int i = 0; i < 5; i++) begin
      drive_same(0, 0, 0, int'($urandom_range(0, 65535)) - 32768,
                 int'($urandom_range(0, 65535)) - 32768, 6, 0, "hold");
    end
    drive_same(0, 1, 0, 9, 9, 0, 0, "clr_no_en");
    drive_same(0, 0, 0, 9, 9, 0, 0, "hold_after_clr");

    // Positive overflow: build 0x7FFF0000 then add 0x00020000.
    drive_same(0, 1, 1, -32768, -32768, 'h4000_0000, 0, "pos_build_0");
    drive_same(0, 0, 1, 32767, 32767, 'h7FFF_0001, 0, "pos_build_1");
    drive_same(0, 0, 1, 1, -1, 'h7FFF_0000, 0, "pos_build_2");
    drive(0, 0, 1, 512, 256, 'h8001_0000, 1, 'h7FFF_FFFF, 1, "pos_overflow");
    drive(0, 0, 1, 1, 1, 'h8001_0001, 1, 'h7FFF_FFFF, 1, "pos_ovf_sticky");
    drive(0, 0, 0, 1, 1, 'h8001_0001, 1, 'h7FFF_FFFF, 1, "pos_ovf_hold");
    drive_same(0, 1, 0, 1, 1, 0, 0, "pos_ovf_clr");

    // Negative overflow: build 0x80000000 then add -1.
    drive_same(0, 1, 1, -32768, 32767, 'hC000_8000, 0, "neg_build_0");
    drive_same(0, 0, 1, -32768, 32767, 'h8001_0000, 0, "neg_build_1");
    drive_same(0, 0, 1, -32768, 1, 'h8000_8000, 0, "neg_build_2");
    drive_same(0, 0, 1, -32768, 1, 'h8000_0000, 0, "neg_build_3");
    drive(0, 0, 1, 1, -1, 'h7FFF_FFFF, 1, 'h8000_0000, 1, "neg_overflow");
    drive_same(1, 0, 1, 5, 7, 0, 0, "reset_clears_ovf");
    drive_same(0, 0, 1, 5, 7, 35, 0, "acc_after_reset");

    drive_same(0, 1, 1, 1, 9, 9, 0, "b2b_clr_0");
    drive_same(0, 1, 1, -3, 3, -9, 0, "b2b_clr_1");
    drive_same(0, 0, 1, 1, 1, -8, 0, "b2b_acc");

    drive_same(0, 0, 1, 4, 5, 12, 0, "pre_reset_acc");
    drive_same(1, 0, 1, 4, 5, 0, 0, "mid_window_reset");
    drive_same(1, 1, 1, 2, 3, 0, 0, "reset_over_clr");
    drive_same(0, 0, 0, 2, 3, 0, 0, "idle_after_reset");

    for (int i = 0; i < 8 && exp_q.size() > 0; i++) begin
      @(posedge clk);
    end
    @(posedge clk);
    #3;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: pending=%0d expected pending=0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
